inst_mem_loader: RTL and testbench

Writes program words into the writable instruction memory from a byte stream, so the core can be reprogrammed without re-synthesising the ROM image. Sits between a byte source (UART/debug receiver) and the write port of the instruction memory. Holds the core in `core_hold` while a load session runs. Assembles little-endian bytes into 32-bit words and writes them at consecutive word addresses starting from 0.

---
 rtl/inst_mem_loader_pkg.sv | 13 +
 rtl/inst_mem_loader_byte_packer.sv | 36 +++
 rtl/inst_mem_loader.sv | 97 +++++++++
 tb/tb_inst_mem_loader.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/inst_mem_loader_pkg.sv
// inst_mem_loader_pkg: shared state encoding and instruction-memory geometry
package inst_mem_loader_pkg;
    localparam int IMEM_ADDR_W    = 6;
    localparam int IMEM_DEPTH     = 64;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;
endpackage

// File: rtl/inst_mem_loader_byte_packer.sv
// byte_packer: assembles little-endian bytes into one instruction word
//   i_clk, i_rst_n : clock, async active-low reset
//   i_clear        : restart at byte 0 (new session)
//   i_accept       : a byte is taken this cycle
//   i_byte         : the byte being taken
//   o_word         : assembled word; captured bytes are held between accepts
//   o_word_full    : the byte taken this cycle completes the word
module byte_packer
    import inst_mem_loader_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_clear,
    input  logic        i_accept,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_word_full
);
    logic [1:0]  r_cnt;
    logic [31:0] r_word;

    assign o_word      = r_word;
    assign o_word_full = i_accept && (r_cnt == 2'(BYTES_PER_WORD - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt  <= '0;
            r_word <= '0;
        end else if (i_clear) begin
            r_cnt  <= '0;
        end else if (i_accept) begin
            r_word[8*r_cnt +: 8] <= i_byte;
            r_cnt                <= r_cnt + 2'd1;
        end
    end
endmodule

// File: rtl/inst_mem_loader.sv
// inst_mem_loader: loads instruction memory words from a byte stream
//   i_clk, i_rst_n      : clock, async active-low reset
//   i_start, i_num_words: begin a session of i_num_words words (IDLE only)
//   i_abort             : end the session, partial word dropped, err set
//   i_byte_valid/_data  : byte source; o_byte_ready is the handshake
//   o_wr_en/_addr/_data : instruction memory write port
//   o_busy, o_core_hold : session in progress / stall the core
//   o_done              : one-cycle pulse at session end
//   o_err               : sticky, illegal count or abort
module inst_mem_loader
    import inst_mem_loader_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W,
    parameter int DEPTH  = IMEM_DEPTH
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [ADDR_W:0]   i_num_words,
    input  logic              i_abort,
    input  logic              i_byte_valid,
    input  logic [7:0]        i_byte_data,
    output logic              o_byte_ready,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [31:0]       o_wr_data,
    output logic              o_busy,
    output logic              o_core_hold,
    output logic              o_done,
    output logic              o_err
);
    state_t            r_state, w_next;
    logic [ADDR_W:0]   r_rem;
    logic [ADDR_W-1:0] r_addr;
    logic              r_err;
    logic              w_in_sess, w_start, w_illegal, w_accept, w_word_full;

    assign w_in_sess    = (r_state == ST_RECV) || (r_state == ST_WRITE);
    assign w_start      = (r_state == ST_IDLE) && i_start;
    assign w_illegal    = (i_num_words == '0) || (i_num_words > (ADDR_W+1)'(DEPTH));
    // abort wins over the byte handshake and over the write strobe
    assign o_byte_ready = (r_state == ST_RECV) && !i_abort;
    assign w_accept     = o_byte_ready && i_byte_valid;
    assign o_wr_en      = (r_state == ST_WRITE) && !i_abort;
    assign o_wr_addr    = r_addr;
    assign o_busy       = w_in_sess;
    assign o_core_hold  = w_in_sess;
    assign o_done       = (r_state == ST_DONE);
    assign o_err        = r_err;

    byte_packer u_packer (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_clear    (w_start),
        .i_accept   (w_accept),
        .i_byte     (i_byte_data),
        .o_word     (o_wr_data),
        .o_word_full(w_word_full)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  w_next = i_start ? (w_illegal ? ST_DONE : ST_RECV) : ST_IDLE;
            ST_RECV:  w_next = i_abort ? ST_IDLE : (w_word_full ? ST_WRITE : ST_RECV);
            ST_WRITE: w_next = i_abort ? ST_IDLE : ((r_rem == 1) ? ST_DONE : ST_RECV);
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_rem   <= '0;
            r_addr  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_start) begin
                r_err <= w_illegal;
                if (!w_illegal) begin
                    r_rem  <= i_num_words;
                    r_addr <= '0;
                end
            end
            if (i_abort && w_in_sess)
                r_err <= 1'b1;
            if (o_wr_en) begin
                r_rem <= r_rem - 1'b1;
                // the last word keeps its address so a full-depth load never wraps
                if (r_rem != 1)
                    r_addr <= r_addr + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_inst_mem_loader.sv
// tb_inst_mem_loader: scoreboard bench for inst_mem_loader
module tb_inst_mem_loader;
    logic        clk = 0, rst_n = 0, start = 0, abort = 0, bv = 0;
    logic [6:0]  num = 0;
    logic [7:0]  bd = 0;
    logic        br, wr_en, busy, hold, done, err;
    logic [5:0]  wa;
    logic [31:0] wd;

    int vectors = 0, miscompares = 0, cyc = 0, done_cnt = 0, last_done_cyc = 0;
    logic [37:0] exp_q[$];

    inst_mem_loader dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_num_words(num),
        .i_abort(abort), .i_byte_valid(bv), .i_byte_data(bd),
        .o_byte_ready(br), .o_wr_en(wr_en), .o_wr_addr(wa), .o_wr_data(wd),
        .o_busy(busy), .o_core_hold(hold), .o_done(done), .o_err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) if (rst_n) begin
        if (wr_en) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_wr: got addr %0d data %08h expected no write", wa, wd);
            end else
                chk("wr", {wa, wd}, exp_q.pop_front());
        end
        if (done) begin
            done_cnt++;
            last_done_cyc = cyc;
        end
    end

    task automatic do_start(input int n);
        start = 1;
        num = 7'(n);
        @(posedge clk); #1;
        start = 0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, input bit chk_hold);
        int n = 0;
        bv = 0;
        repeat (gap) begin
            @(negedge clk);
            if (chk_hold) chk("hold_gap", hold, 1);
            @(posedge clk); #1;
        end
        bv = 1;
        bd = b;
        do begin @(negedge clk); n++; end while (!br && n < 200);
        if (n >= 200) chk("byte_ready_timeout", 0, 1);
        @(posedge clk); #1;
        bv = 0;
    endtask

    task automatic wait_done(input int prev);
        int n = 0;
        while (done_cnt == prev && n < 3000) begin @(negedge clk); n++; end
        if (n >= 3000) chk("done_timeout", done_cnt, prev + 1);
        @(posedge clk); #1;
    endtask

    // sends n words of the given payload; stop_after >= 0 returns early after that many bytes
    task automatic session(input logic [31:0] words[$], input int gapmax, input bit chk_hold,
                           input int stop_after);
        int sent = 0;
        foreach (words[w]) begin
            exp_q.push_back({6'(w), words[w]});
            for (int k = 0; k < 4; k++) begin
                if (stop_after >= 0 && sent == stop_after) return;
                send_byte(words[w][8*k +: 8], $urandom_range(gapmax, 0), chk_hold);
                sent++;
            end
        end
    endtask

    task automatic rand_words(input int n, output logic [31:0] q[$]);
        q = {};
        repeat (n) q.push_back($urandom);
    endtask

    task automatic check_reset_outputs(input string name);
        chk(name, {br, wr_en, busy, hold, done, err, wa, wd}, '0);
    endtask

    initial begin
        logic [31:0] words[$];
        int t, d0, n;
        #12 rst_n = 1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("post_reset_idle", {br, busy, done, err}, 0);
        @(posedge clk); #1;

        // reset asserted mid-cycle clears every output at once
        #2 rst_n = 0;
        #1 check_reset_outputs("async_reset_idle");
        @(posedge clk); #1 rst_n = 1;

        // two-word load, back to back
        words = '{32'h00002083, 32'h00402103};
        d0 = done_cnt;
        t = cyc;
        do_start(2);
        session(words, 0, 0, -1);
        wait_done(d0);
        chk("two_word_latency", last_done_cyc - t, 11);
        chk("two_word_err", err, 0);
        chk("two_word_drain", exp_q.size(), 0);

        // same stream with three idle cycles before every byte
        d0 = done_cnt;
        do_start(2);
        for (int w = 0; w < 2; w++) begin
            exp_q.push_back({6'(w), words[w]});
            for (int k = 0; k < 4; k++) send_byte(words[w][8*k +: 8], 3, 1);
        end
        wait_done(d0);
        chk("bp_done_count", done_cnt, d0 + 1);
        chk("bp_drain", exp_q.size(), 0);

        // illegal counts
        foreach (words[i]) ;
        for (int i = 0; i < 3; i++) begin
            n = (i == 0) ? 0 : (i == 1) ? 65 : $urandom_range(127, 66);
            do_start(n);
            @(negedge clk);
            chk("illegal_done_err", {done, err, busy}, 3'b110);
            @(posedge clk); #1;
        end

        // abort after two bytes of a one-word session
        d0 = done_cnt;
        do_start(1);
        send_byte(8'h13, 0, 0);
        send_byte(8'h05, 0, 0);
        abort = 1;
        @(posedge clk); #1;
        abort = 0;
        @(negedge clk);
        chk("abort_idle", {busy, br, err}, 3'b001);
        repeat (3) @(posedge clk);
        #1;
        chk("abort_no_done", done_cnt, d0);
        rand_words(1, words);
        d0 = done_cnt;
        do_start(1);
        @(negedge clk);
        chk("start_clears_err", {err, busy}, 2'b01);
        @(posedge clk); #1;
        session(words, 1, 0, -1);
        wait_done(d0);
        chk("after_abort_drain", exp_q.size(), 0);

        // randomized legal sessions
        for (int s = 0; s < 6; s++) begin
            n = $urandom_range(8, 1);
            rand_words(n, words);
            d0 = done_cnt;
            t = cyc;
            do_start(n);
            session(words, (s % 2 == 0) ? 0 : 2, 1, -1);
            wait_done(d0);
            if (s % 2 == 0) chk("rand_latency", last_done_cyc - t, 1 + 5 * n);
            chk("rand_err", err, 0);
            chk("rand_drain", exp_q.size(), 0);
        end

        // full depth
        rand_words(64, words);
        d0 = done_cnt;
        t = cyc;
        do_start(64);
        session(words, 0, 0, -1);
        wait_done(d0);
        chk("full_latency", last_done_cyc - t, 1 + 5 * 64);
        chk("full_drain", exp_q.size(), 0);
        repeat (5) @(posedge clk);
        #1;
        chk("full_single_done", done_cnt, d0 + 1);

        // async reset during word 30 stops all writes
        rand_words(64, words);
        d0 = done_cnt;
        do_start(64);
        session(words, 1, 0, 30 * 4 + 2);
        #2 rst_n = 0;
        #1 check_reset_outputs("midsession_reset");
        chk("midsession_pending", exp_q.size(), 1);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        repeat (20) @(posedge clk);
        #1;
        chk("midsession_no_done", done_cnt, d0);
        chk("midsession_idle", {busy, br}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
